// File: rtl/vga_native_arbiter.sv
// vga_native_arbiter
//   Shares the native VGA register-bank port between two requesters.
//   Port 0 is the AXI-lite bridge side, port 1 an internal requester.
//   One transaction in flight at a time, sequenced IDLE -> ACCESS ->
//   (CAPTURE, reads only) -> RESP -> IDLE.
//
// Ports:
//   clk, arst_n                 clock, asynchronous active-low reset
//   reqN_valid/ready/we/addr/wdata  command channel of port N (N = 0, 1)
//   rspN_valid, rspN_rdata          one-cycle response pulse, read data
//   mem_write_en, mem_read_en       native strobes (only high in ACCESS)
//   mem_addr, mem_wdata, mem_rdata  native address/data; mem_rdata is
//                                   valid the cycle after mem_read_en
//
// Build option:
//   VGA_NATIVE_ARB_FIXED_PRIO_EN  defined   -> port 0 always wins a tie
//                                 undefined -> round-robin on ties
module vga_native_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              mem_write_en,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t              state_q,        state_d;
  logic                grant_q,        grant_d;
  logic                we_q,           we_d;
  logic                mem_write_en_q, mem_write_en_d;
  logic                mem_read_en_q,  mem_read_en_d;
  logic [ADDR_W-1:0]   mem_addr_q,     mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q,    mem_wdata_d;
  logic                rsp0_valid_q,   rsp0_valid_d;
  logic                rsp1_valid_q,   rsp1_valid_d;
  logic [DATA_W-1:0]   rsp0_rdata_q,   rsp0_rdata_d;
  logic [DATA_W-1:0]   rsp1_rdata_q,   rsp1_rdata_d;
`ifndef VGA_NATIVE_ARB_FIXED_PRIO_EN
  logic                last_grant_q,   last_grant_d;
`endif

  logic any_valid;
  logic win1;
  logic sel_we;

  // Arbitration: win1 selects port 1 as the winner of this IDLE cycle.
  always_comb begin
    any_valid = req0_valid | req1_valid;
`ifdef VGA_NATIVE_ARB_FIXED_PRIO_EN
    win1 = req1_valid & ~req0_valid;
`else
    // On a tie the port that did not win last time is granted.
    win1 = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
`endif
  end

  // Ready is combinational and only offered to the winner while idle.
  assign req0_ready = (state_q == S_IDLE) & any_valid & ~win1;
  assign req1_ready = (state_q == S_IDLE) & win1;

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    we_d           = we_q;
    mem_write_en_d = 1'b0;
    mem_read_en_d  = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    rsp0_valid_d   = 1'b0;
    rsp1_valid_d   = 1'b0;
    rsp0_rdata_d   = rsp0_rdata_q;
    rsp1_rdata_d   = rsp1_rdata_q;
`ifndef VGA_NATIVE_ARB_FIXED_PRIO_EN
    last_grant_d   = last_grant_q;
`endif
    sel_we         = win1 ? req1_we : req0_we;

    unique case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          grant_d     = win1;
          we_d        = sel_we;
          mem_addr_d  = win1 ? req1_addr  : req0_addr;
          mem_wdata_d = win1 ? req1_wdata : req0_wdata;
`ifndef VGA_NATIVE_ARB_FIXED_PRIO_EN
          last_grant_d = win1;
`endif
          // Strobes are registered, so they are raised on the accepting
          // edge to be visible for exactly the ACCESS cycle.
          mem_write_en_d = sel_we;
          mem_read_en_d  = ~sel_we;
          state_d        = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (we_q) begin
          rsp0_valid_d = ~grant_q;
          rsp1_valid_d = grant_q;
          state_d      = S_RESP;
        end else begin
          state_d      = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        // mem_rdata is valid now; capture and raise the response together.
        if (grant_q) rsp1_rdata_d = mem_rdata;
        else         rsp0_rdata_d = mem_rdata;
        rsp0_valid_d = ~grant_q;
        rsp1_valid_d = grant_q;
        state_d      = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q        <= S_IDLE;
      grant_q        <= 1'b0;
      we_q           <= 1'b0;
      mem_write_en_q <= 1'b0;
      mem_read_en_q  <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      rsp0_valid_q   <= 1'b0;
      rsp1_valid_q   <= 1'b0;
      rsp0_rdata_q   <= '0;
      rsp1_rdata_q   <= '0;
`ifndef VGA_NATIVE_ARB_FIXED_PRIO_EN
      last_grant_q   <= 1'b1;
`endif
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      we_q           <= we_d;
      mem_write_en_q <= mem_write_en_d;
      mem_read_en_q  <= mem_read_en_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      rsp0_valid_q   <= rsp0_valid_d;
      rsp1_valid_q   <= rsp1_valid_d;
      rsp0_rdata_q   <= rsp0_rdata_d;
      rsp1_rdata_q   <= rsp1_rdata_d;
`ifndef VGA_NATIVE_ARB_FIXED_PRIO_EN
      last_grant_q   <= last_grant_d;
`endif
    end
  end

  assign mem_write_en = mem_write_en_q;
  assign mem_read_en  = mem_read_en_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign rsp0_valid   = rsp0_valid_q;
  assign rsp1_valid   = rsp1_valid_q;
  assign rsp0_rdata   = rsp0_rdata_q;
  assign rsp1_rdata   = rsp1_rdata_q;

endmodule

// File: tb/tb_vga_native_arbiter.sv
// Testbench for vga_native_arbiter: a behavioural register bank sits on the
// native port; a scoreboard queue holds each accepted command with its
// expected strobe, latency and read data, popped when the response appears.
module tb_vga_native_arbiter;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        req0_valid = 1'b0, req0_we = 1'b0;
  logic [7:0]  req0_addr = '0;
  logic [31:0] req0_wdata = '0;
  logic        req1_valid = 1'b0, req1_we = 1'b0;
  logic [7:0]  req1_addr = '0;
  logic [31:0] req1_wdata = '0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic        mem_write_en, mem_read_en;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  vga_native_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .arst_n(arst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    bit          we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          acc;
  } txn_t;

  txn_t        sbq[$];
  int          grant_log[$];
  bit   [31:0] bank[256];
  bit   [31:0] model_mem[256];
  logic [31:0] last_rd[2];
  int          cyc = 0;
  int          lg_m = 1;
  int          errors = 0;
  int          checks = 0;
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Native register bank; read data registered one cycle after the strobe.
  always @(posedge clk) begin
    if (pl_en)        bank[pl_addr]  <= pl_data;
    if (mem_write_en) bank[mem_addr] <= mem_wdata;
    if (mem_read_en)  mem_rdata      <= bank[mem_addr];
  end

  // Monitor / scoreboard, sampling on the falling edge.
  always @(negedge clk) begin
    int   exp_p;
    bit   idle_m;
    txn_t t;
    cyc++;
    if (!arst_n) begin
      sbq.delete();
      lg_m = 1;
      last_rd[0] = '0;
      last_rd[1] = '0;
    end else begin
      if (pl_en) model_mem[pl_addr] = pl_data;
      idle_m = (sbq.size() == 0);

      if (req0_valid || req1_valid) begin
`ifdef VGA_NATIVE_ARB_FIXED_PRIO_EN
        exp_p = req0_valid ? 0 : 1;
`else
        if (req0_valid && req1_valid) exp_p = (lg_m == 0) ? 1 : 0;
        else                          exp_p = req1_valid ? 1 : 0;
`endif
        check("ready", {30'd0, req1_ready, req0_ready},
              idle_m ? ((exp_p == 1) ? 32'd2 : 32'd1) : 32'd0);
        if (req0_valid && req0_ready) grant_log.push_back(0);
        else if (req1_valid && req1_ready) grant_log.push_back(1);
        if (idle_m) begin
          t.port  = exp_p;
          t.we    = (exp_p == 1) ? req1_we : req0_we;
          t.addr  = (exp_p == 1) ? req1_addr : req0_addr;
          t.wdata = (exp_p == 1) ? req1_wdata : req0_wdata;
          t.acc   = cyc;
          if (t.we) model_mem[t.addr] = t.wdata;
          t.rdata = model_mem[t.addr];
          lg_m = exp_p;
          sbq.push_back(t);
        end
      end else if (req0_ready || req1_ready) begin
        check("ready_no_valid", {30'd0, req1_ready, req0_ready}, 32'd0);
      end

      if (mem_write_en || mem_read_en) begin
        check("strobe_excl", {31'd0, mem_write_en & mem_read_en}, 32'd0);
        if (sbq.size() == 0) check("stray_strobe", 32'd1, 32'd0);
        else begin
          t = sbq[0];
          check("strobe_lat", cyc - t.acc, 32'd1);
          check("strobe_kind", {30'd0, mem_write_en, mem_read_en}, t.we ? 32'd2 : 32'd1);
          check("mem_addr", {24'd0, mem_addr}, {24'd0, t.addr});
          if (t.we) check("mem_wdata", mem_wdata, t.wdata);
        end
      end

      if (rsp0_valid || rsp1_valid) begin
        if (sbq.size() == 0) check("stray_rsp", 32'd1, 32'd0);
        else begin
          t = sbq.pop_front();
          check("rsp_port", {30'd0, rsp1_valid, rsp0_valid}, (t.port == 1) ? 32'd2 : 32'd1);
          check("rsp_lat", cyc - t.acc, t.we ? 32'd2 : 32'd3);
          if (!t.we) last_rd[t.port] = t.rdata;
          check("rsp_rdata", (t.port == 1) ? rsp1_rdata : rsp0_rdata, last_rd[t.port]);
        end
      end else if (sbq.size() > 0 && (cyc - sbq[0].acc) > 4) begin
        check("rsp_timeout", 32'd0, 32'd1);
        void'(sbq.pop_front());
      end
    end
  end

  function automatic logic rdy(input int p);
    return (p == 1) ? req1_ready : req0_ready;
  endfunction

  task automatic set_req(input int p, input logic v, input logic we,
                         input logic [7:0] a, input logic [31:0] d);
    if (p == 1) begin
      req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
    end else begin
      req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
    end
  endtask

  // Called just after a rising edge; holds the request until accepted.
  task automatic send(input int p, input logic we, input logic [7:0] a, input logic [31:0] d);
    int n;
    n = 0;
    set_req(p, 1'b1, we, a, d);
    @(negedge clk);
    while (!rdy(p) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!rdy(p)) begin
      check("accept_timeout", 32'd0, 32'd1);
      set_req(p, 1'b0, 1'b0, '0, '0);
      return;
    end
    @(posedge clk);
    #1;
    set_req(p, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk);
    #1;
    pl_en = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctrl"}, {26'd0, req0_ready, req1_ready, rsp0_valid, rsp1_valid,
                           mem_write_en, mem_read_en}, 32'd0);
    check({tag, "_addr"}, {24'd0, mem_addr}, 32'd0);
    check({tag, "_wdata"}, mem_wdata, 32'd0);
    check({tag, "_rdata0"}, rsp0_rdata, 32'd0);
    check({tag, "_rdata1"}, rsp1_rdata, 32'd0);
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int e;

    // Reset state
    arst_n = 1'b0;
    #100;
    check_outputs_zero("rst");
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    @(posedge clk);
    #1;

    // Port 0 write
    send(0, 1'b1, 8'h04, 32'hDEADBEEF);
    drain();

    // Port 1 read of preloaded word
    preload(8'h10, 32'h12345678);
    send(1, 1'b0, 8'h10, 32'h0);
    drain();
    check("rd_rsp1_rdata", rsp1_rdata, 32'h12345678);
    check("rd_rsp0_rdata", rsp0_rdata, 32'h0);

    // Contention: both ports continuously valid, fresh reset so port 0 wins first
    do_reset();
    base = grant_log.size();
    fork
      for (int i = 0; i < 4; i++) send(0, 1'b1, 8'h30 + 8'(i), 32'hC0DE0000 + i);
      for (int j = 0; j < 4; j++) send(1, 1'b0, 8'h30 + 8'(j), 32'h0);
    join
    drain();
    check("grant_cnt", grant_log.size() - base, 32'd8);
    for (int k = 0; k < 8 && base + k < grant_log.size(); k++) begin
`ifdef VGA_NATIVE_ARB_FIXED_PRIO_EN
      e = (k < 4) ? 0 : 1;
`else
      e = k % 2;
`endif
      check("grant_order", grant_log[base + k], e);
    end

    // Simultaneous write (port 0) and read (port 1) of the same word
    base = grant_log.size();
    fork
      send(0, 1'b1, 8'h20, 32'hA5A5A5A5);
      send(1, 1'b0, 8'h20, 32'h0);
    join
    drain();
    check("wtr_cnt", grant_log.size() - base, 32'd2);
    if (grant_log.size() >= base + 2) begin
      check("wtr_first", grant_log[base], 32'd0);
      check("wtr_second", grant_log[base + 1], 32'd1);
    end
    check("wtr_rdata", rsp1_rdata, 32'hA5A5A5A5);

    // Random traffic on both ports
    fork
      for (int i = 0; i < 50; i++) begin
        int n0;
        n0 = $urandom_range(0, 10);
        if (n0 > 0) begin
          repeat (n0) @(posedge clk);
          #1;
        end
        send(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom);
      end
      for (int j = 0; j < 50; j++) begin
        int n1;
        n1 = $urandom_range(0, 10);
        if (n1 > 0) begin
          repeat (n1) @(posedge clk);
          #1;
        end
        send(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom);
      end
    join
    drain();

    // Reset during CAPTURE of a read: response is dropped
    send(1, 1'b0, 8'h10, 32'h0);
    @(posedge clk);
    #1;
    arst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("midrst_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    preload(8'h44, 32'h0BADF00D);
    send(0, 1'b0, 8'h44, 32'h0);
    drain();
    check("post_rst_rdata", rsp0_rdata, 32'h0BADF00D);
    check("post_rst_rdata1", rsp1_rdata, 32'h0);
    check("sb_empty", sbq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vga_native_arbiter.md
Name: vga_native_arbiter

Overview:
- Shares one native register port (the VGA register bank behind the AXI-lite slave FSM) between two requesters.
- Port 0 is the AXI-lite bridge side; port 1 is an internal requester (e.g. palette/config loader).
- Round-robin arbitration; one outstanding transaction at a time. Each access is sequenced through a small FSM that drives write_en/read_en and returns a registered response.

Parameters:
- ADDR_W, 8, native word-address width
- DATA_W, 32, data width (matches AXI-lite data width)

Ports:
- clk  in  1  system clock
- arst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  port 0 command valid
- req0_ready  out  1  port 0 command accepted
- req0_we  in  1  port 0: 1 = write, 0 = read
- req0_addr  in  ADDR_W  port 0 address
- req0_wdata  in  DATA_W  port 0 write data
- rsp0_valid  out  1  port 0 response pulse
- rsp0_rdata  out  DATA_W  port 0 read data
- req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata: same as port 0, for port 1
- mem_write_en  out  1  native write strobe
- mem_read_en  out  1  native read strobe
- mem_addr  out  ADDR_W  native address
- mem_wdata  out  DATA_W  native write data
- mem_rdata  in  DATA_W  native read data, valid the cycle after mem_read_en

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on arst_n.
- Reset values:
  - state = IDLE; last_grant = 1, so port 0 wins the first tie.
  - All outputs 0: ready, rsp_valid, mem_* strobes, mem_addr, mem_wdata, rsp*_rdata.
- States: IDLE, ACCESS, CAPTURE, RESP.
- IDLE:
  - reqX_ready = 1 combinationally, only for the arbitration winner and only in IDLE.
  - Winner: the single valid port. If both are valid, the port != last_grant wins.
  - On the accepting edge: latch we/addr/wdata and the grant id, update last_grant, go to ACCESS.
  - No valid: stay in IDLE.
- ACCESS (1 cycle):
  - mem_addr/mem_wdata = latched values.
  - Write: mem_write_en = 1, then go to RESP.
  - Read: mem_read_en = 1, then go to CAPTURE.
- CAPTURE (reads only):
  - Register mem_rdata into the granted port's rspX_rdata; go to RESP.
- RESP:
  - rspX_valid = 1 for exactly one cycle on the granted port only, then go to IDLE.
  - No response backpressure; requesters must accept.
  - rspX_rdata holds its value until that port's next read capture.
  - For writes, rspX_rdata is unchanged.
- Latency, from the accepting edge:
  - Write: strobe at +1 cycle, rsp_valid at +2.
  - Read: strobe at +1, rsp_valid at +3.
  - Next accept is possible in the cycle after RESP.
- Strobes are mutually exclusive; at most one is high per cycle, and only in ACCESS.
- A valid request must be held stable until ready. A deasserted valid while not ready is legal and simply not granted.
- Reset mid-operation: immediate return to IDLE. The in-flight transaction is dropped with no response and no further strobe.

Optional Feature:
- Macro VGA_NATIVE_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; port 0 always wins when both are valid, and last_grant is unused.
- Undefined (default): round-robin as described above.

Test Plan:
- Reset check: hold arst_n = 0 for 100ns -> all outputs 0. After release, port 0 write addr 0x04 data 0xDEADBEEF -> mem_write_en at accept+1 with mem_addr 0x04, mem_wdata 0xDEADBEEF; rsp0_valid pulse at accept+2.
- Read path: preload bank[0x10] = 0x12345678; port 1 read addr 0x10 -> mem_read_en at +1, rsp1_valid at +3 with rsp1_rdata 0x12345678; rsp0_valid stays 0.
- Contention: both ports continuously valid for 4 transactions each -> grants alternate 0,1,0,1... (first grant port 0). With VGA_NATIVE_ARB_FIXED_PRIO_EN, all 4 port 0 transactions complete before any port 1 grant.
- Write-then-read: port 0 write 0x20 = 0xA5A5A5A5 while port 1 simultaneously reads 0x20 -> port 0 is granted first; port 1 read returns 0xA5A5A5A5.
- Random traffic: 50 random word-address transactions per port with 0-10 idle cycles, scoreboarded against a model -> all read data matches; never both strobes in one cycle.
- Mid-operation reset: assert arst_n = 0 during CAPTURE of a read -> no rsp_valid, state IDLE, outputs 0. The next transaction after release completes normally.
